// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for the fle/ble4 configuration chain.
// Serializes words MSB-first onto ccff_head and captures the old image from ccff_tail.
module ccff_bitstream_loader #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CHAIN_LEN  = 17
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  ccff_head,
    output logic                  ccff_shift_en,
    input  logic                  ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic [CHAIN_LEN-1:0]  readback,
    output logic                  readback_valid
);

    localparam int unsigned RW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BW = $clog2(WORD_WIDTH + 1);
    localparam logic [RW-1:0] LEN  = RW'(CHAIN_LEN);
    localparam logic [BW-1:0] WLEN = BW'(WORD_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   shreg_q;
    logic [RW-1:0]           remaining_q;
    logic [BW-1:0]           word_bits_q;
    logic [BW-1:0]           first_bits;
    logic                    load, accept, shift, finish, kill;

    // A short final word only contributes the bits the chain still needs.
    always_comb begin
        if (32'(remaining_q) < WORD_WIDTH) begin
            first_bits = BW'(remaining_q);
        end else begin
            first_bits = WLEN;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        shift   = 1'b0;
        finish  = 1'b0;
        kill    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = WAIT_WORD;
                    load    = 1'b1;
                end
            end
            WAIT_WORD: begin
                if (abort) begin
                    state_d = IDLE;
                    kill    = 1'b1;
                end else if (cfg_valid) begin
                    state_d = SHIFT;
                    accept  = 1'b1;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    kill    = 1'b1;
                end else if (word_bits_q == BW'(1)) begin
                    if (remaining_q == RW'(1)) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = WAIT_WORD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            remaining_q    <= '0;
            word_bits_q    <= '0;
            readback       <= '0;
            readback_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                remaining_q    <= LEN;
                readback_valid <= 1'b0;
            end
            if (accept) begin
                shreg_q     <= cfg_data;
                word_bits_q <= first_bits;
            end
            if (shift) begin
                shreg_q     <= {shreg_q[WORD_WIDTH-2:0], 1'b0};
                readback    <= {readback[CHAIN_LEN-2:0], ccff_tail};
                word_bits_q <= word_bits_q - BW'(1);
                remaining_q <= remaining_q - RW'(1);
            end
            if (finish) begin
                readback_valid <= 1'b1;
            end
            if (kill) begin
                readback_valid <= 1'b0;
            end
        end
    end

    // Outputs decode the state flops, so reset clears them without a clock.
    assign cfg_ready     = (state_q == WAIT_WORD);
    assign ccff_shift_en = (state_q == SHIFT);
    assign ccff_head     = ccff_shift_en & shreg_q[WORD_WIDTH-1];
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a chain model on head/tail plus a
// scoreboard of expected head bits and expected readback images.
module tb_ccff_bitstream_loader;

    localparam int W = 8;
    localparam int L = 17;

    typedef struct packed {
        logic [L-1:0] rb;
        logic [L-1:0] fin;
    } done_t;

    logic         prog_clk;
    logic         prog_reset_n;
    logic         start;
    logic         abort;
    logic [W-1:0] cfg_data;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         ccff_head;
    logic         ccff_shift_en;
    logic         ccff_tail;
    logic         busy;
    logic         done;
    logic [L-1:0] readback;
    logic         readback_valid;

    ccff_bitstream_loader #(.WORD_WIDTH(W), .CHAIN_LEN(L)) dut (
        .prog_clk       (prog_clk),
        .prog_reset_n   (prog_reset_n),
        .start          (start),
        .abort          (abort),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .ccff_head      (ccff_head),
        .ccff_shift_en  (ccff_shift_en),
        .ccff_tail      (ccff_tail),
        .busy           (busy),
        .done           (done),
        .readback       (readback),
        .readback_valid (readback_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic   exp_bits[$];
    done_t  exp_done[$];

    logic [L-1:0] chain;
    logic [L-1:0] preload_val;
    logic         preload_req;

    int           model_pos;
    logic [L-1:0] model_vec;
    logic [L-1:0] rb_exp;

    int cyc = 0;
    int shift_cnt = 0;
    int last_shift = -10;

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Behaviour of the downstream configuration chain.
    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = chain[L-1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor: compares every shift pulse and every done pulse.
    always @(negedge prog_clk) begin
        logic  b;
        done_t e;
        cyc = cyc + 1;
        if (prog_reset_n) begin
            if (!busy) shift_cnt = 0;
            if (ccff_shift_en) begin
                shift_cnt = shift_cnt + 1;
                last_shift = cyc;
                if (exp_bits.size() == 0) begin
                    bad("extra_shift");
                end else begin
                    b = exp_bits.pop_front();
                    chk("head_bit", 32'(ccff_head), 32'(b));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    bad("extra_done");
                end else begin
                    e = exp_done.pop_front();
                    chk("readback", 32'(readback), 32'(e.rb));
                    chk("rb_valid_at_done", 32'(readback_valid), 32'd1);
                    chk("chain_image", 32'(chain), 32'(e.fin));
                    chk("shift_count", shift_cnt, L);
                    chk("done_latency", cyc - last_shift, 1);
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Expected bits of a load: the word stream MSB-first, cut at L bits.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            if (model_pos < L) begin
                exp_bits.push_back(w[i]);
                model_vec = {model_vec[L-2:0], w[i]};
                model_pos++;
                if (model_pos == L) exp_done.push_back('{rb: rb_exp, fin: model_vec});
            end
        end
    endtask

    task automatic preload(input logic [L-1:0] v);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge prog_clk);
        preload_req = 1'b0;
    endtask

    task automatic start_load();
        chk("idle_before_start", 32'(busy), 32'd0);
        rb_exp    = chain;
        model_pos = 0;
        model_vec = '0;
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_first_wait", 32'(cfg_ready), 32'd1);
        chk("rbv_cleared", 32'(readback_valid), 32'd0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap,
                             input bit early, input bit sb);
        int n;
        if (early) begin
            cfg_valid = 1'b1;
            cfg_data  = ~w;
        end
        if (sb) begin
            start = 1'b1;
            @(negedge prog_clk);
            start = 1'b0;
        end
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        if (!cfg_ready) begin
            bad("ready_timeout");
            cfg_valid = 1'b0;
            return;
        end
        if (gap > 0) cfg_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            chk("gap_ready", 32'(cfg_ready), 32'd1);
            chk("gap_no_shift", 32'(ccff_shift_en), 32'd0);
            @(negedge prog_clk);
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        push_word(w);
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        cfg_data  = W'($urandom);
    endtask

    task automatic finish_load();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        if (busy) bad("done_timeout");
        chk("rbv_holds", 32'(readback_valid), 32'd1);
        chk("no_done_in_idle", 32'(done), 32'd0);
    endtask

    task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input int gap,
                            input bit early, input bit sb);
        start_load();
        send_word(w0, 0, 1'b0, 1'b0);
        send_word(w1, gap, early, sb);
        send_word(w2, gap, early, sb);
        finish_load();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start        = 1'b0;
        abort        = 1'b0;
        cfg_valid    = 1'b0;
        cfg_data     = '0;
        preload_req  = 1'b0;
        preload_val  = '0;
        chain        = '0;
        prog_reset_n = 1'b1;
        #2 prog_reset_n = 1'b0;
        #20;
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_head", 32'(ccff_head), 32'd0);
        chk("rst_shift_en", 32'(ccff_shift_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_readback", 32'(readback), 32'd0);
        chk("rst_rbv", 32'(readback_valid), 32'd0);
        #10 prog_reset_n = 1'b1;
        @(negedge prog_clk);

        // Reference load
        preload(L'($urandom));
        run_load(8'hA5, 8'h3C, 8'h80, 0, 1'b0, 1'b0);
        chk("ref_pattern", 32'(chain), 32'(17'b1010_0101_0011_1100_1));

        // Readback of a known image
        preload(17'h1_5555);
        run_load(W'($urandom), W'($urandom), W'($urandom), 0, 1'b0, 1'b0);
        chk("rb_known_image", 32'(readback), 32'h1_5555);

        // Backpressure between words
        run_load(8'hA5, 8'h3C, 8'h80, 5, 1'b0, 1'b0);
        chk("bp_pattern", 32'(chain), 32'(17'b1010_0101_0011_1100_1));

        // Abort on the 10th shift cycle
        start_load();
        send_word(8'hF0, 0, 1'b0, 1'b0);
        send_word(8'h5A, 0, 1'b0, 1'b0);
        @(negedge prog_clk);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rbv", 32'(readback_valid), 32'd0);
        chk("abort_shift_en", 32'(ccff_shift_en), 32'd0);
        chk("abort_bits_left", exp_bits.size(), 6);
        exp_bits.delete();
        repeat (20) @(negedge prog_clk);
        chk("abort_rbv_later", 32'(readback_valid), 32'd0);
        chk("abort_no_done_q", exp_done.size(), 0);

        // Async reset mid-shift, then a clean load
        start_load();
        send_word(8'hA5, 0, 1'b0, 1'b0);
        @(negedge prog_clk);
        #2 prog_reset_n = 1'b0;
        #1;
        chk("arst_shift_en", 32'(ccff_shift_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(cfg_ready), 32'd0);
        chk("arst_rbv", 32'(readback_valid), 32'd0);
        exp_bits.delete();
        exp_done.delete();
        #4 prog_reset_n = 1'b1;
        @(negedge prog_clk);
        run_load(8'hA5, 8'h3C, 8'h80, 0, 1'b0, 1'b0);
        chk("arst_pattern", 32'(chain), 32'(17'b1010_0101_0011_1100_1));

        // Start while busy and words offered during SHIFT
        run_load(8'hC3, 8'h96, 8'hFF, 0, 1'b1, 1'b1);
        run_load(8'h01, 8'h80, 8'h7F, 2, 1'b1, 1'b1);

        // Randomized loads
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1) preload(L'($urandom));
            run_load(W'($urandom), W'($urandom), W'($urandom),
                     int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge prog_clk);
        chk("bits_drained", exp_bits.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
